button_int_ctrl: RTL and testbench

Front end for the CPU's button interrupt input: synchronizes and debounces four active-low push-buttons, latches each press as a pending request, and presents at most one request at a time on `buttons_pressed`, the CPU top's active-high interrupt input. Requests are issued in fixed priority and paced against the CPU's `cpu_int` state. One request therefore produces exactly one vectored interrupt: 0x0f80, 0x0fa0, 0x0fc0 or 0x0fe0.

---
 rtl/button_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/button_int_ctrl.sv | 99 +++++++++
 tb/tb_button_int_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button interrupt front end: FSM states, button count,
// per-button interrupt vectors and the priority pick.
package button_pkg;

  localparam int unsigned NUM_BTN = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } btn_state_t;

  localparam logic [15:0] INT_VECTOR [NUM_BTN] = '{16'h0f80, 16'h0fa0, 16'h0fc0, 16'h0fe0};

  // Highest-index set bit wins; ascending scan lets the last hit overwrite earlier ones.
  function automatic logic [NUM_BTN-1:0] highest_onehot(input logic [NUM_BTN-1:0] req);
    highest_onehot = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (req[i]) begin
        highest_onehot    = '0;
        highest_onehot[i] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchronizer, inversion to active-high, and a debounce
// counter that accepts a level only after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  assign level = ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (level == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // press is registered alongside the toggle so it lines up with the new stable level
        stable <= level;
        cnt    <= '0;
        press  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_int_ctrl.sv
// Button interrupt front end: debounces four keys, latches presses as pending
// requests and issues them one at a time, paced by the CPU's interrupt state.
module button_int_ctrl
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ACK_TIMEOUT     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTN-1:0]  key_n,
  input  logic                int_active,
  output logic [NUM_BTN-1:0]  buttons_pressed,
  output logic [NUM_BTN-1:0]  pending,
  output logic                merged
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] stable_unused;
  logic [NUM_BTN-1:0] issue_mask;
  logic [NUM_BTN-1:0] bp_d;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      timer_d;
  btn_state_t         state;
  btn_state_t         state_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (key_n[g]),
      .stable (stable_unused[g]),
      .press  (press[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    bp_d       = '0;
    timer_d    = timer;
    issue_mask = '0;
    case (state)
      IDLE: begin
        if ((pending != '0) && !int_active) begin
          issue_mask = highest_onehot(pending);
          bp_d       = issue_mask;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
        timer_d = TW'(ACK_TIMEOUT);
      end
      WAIT_ACK: begin
        if (int_active) begin
          state_d = WAIT_DONE;
        end else if (timer <= TW'(1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!int_active) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A press landing on the bit being issued re-sets it, so set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons_pressed <= '0;
      pending         <= '0;
      merged          <= 1'b0;
      timer           <= '0;
    end else begin
      buttons_pressed <= bp_d;
      pending         <= (pending & ~issue_mask) | press;
      merged          <= |(press & pending);
      timer           <= timer_d;
    end
  end

endmodule

// File: tb/tb_button_int_ctrl.sv
// Bench for button_int_ctrl: directed scenarios plus random key/handler activity,
// checked every cycle against a window-based behavioural model.
module tb_button_int_ctrl;
  import button_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned ACK = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_BTN-1:0] key_n;
  logic               int_active;
  logic [NUM_BTN-1:0] buttons_pressed;
  logic [NUM_BTN-1:0] pending;
  logic               merged;

  int vectors     = 0;
  int miscompares = 0;
  int issue_cnt   = 0;
  int merged_cnt  = 0;

  button_int_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .ACK_TIMEOUT    (ACK)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_n          (key_n),
    .int_active     (int_active),
    .buttons_pressed(buttons_pressed),
    .pending        (pending),
    .merged         (merged)
  );

  always #5 clk = ~clk;

  // Model: a key is accepted when the last DEB synchronized samples all disagree
  // with the accepted level; requests are served by a simple busy/handler tracker.
  logic [NUM_BTN-1:0] hist [DEB+2];
  logic [NUM_BTN-1:0] m_stable, m_press, m_pending, m_bp, clr, old_pend;
  logic               m_merged;
  bit                 waiting, handler, all_diff;
  int                 ack_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEB + 2; j++) hist[j] = '1;
      m_stable = '0; m_press = '0; m_pending = '0; m_bp = '0; m_merged = 1'b0;
      waiting = 0; handler = 0; ack_left = 0;
    end else begin
      old_pend = m_pending;
      m_merged = |(m_press & old_pend);
      clr = '0;
      if (m_bp != '0) begin
        m_bp = '0; waiting = 1; ack_left = ACK;
      end else if (waiting) begin
        if (int_active) begin
          waiting = 0; handler = 1;
        end else begin
          ack_left--;
          if (ack_left == 0) waiting = 0;
        end
      end else if (handler) begin
        if (!int_active) handler = 0;
      end else if (old_pend != '0 && !int_active) begin
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
          if (old_pend[i]) begin
            clr[i] = 1'b1;
            break;
          end
        end
        m_bp = clr;
      end
      m_pending = (old_pend & ~clr) | m_press;

      for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = key_n;
      m_press = '0;
      for (int b = 0; b < NUM_BTN; b++) begin
        all_diff = 1;
        for (int j = 2; j < DEB + 2; j++)
          if (hist[j][b] != m_stable[b]) all_diff = 0;
        if (all_diff) begin
          m_stable[b] = ~m_stable[b];
          m_press[b]  = m_stable[b];
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_bp", buttons_pressed, m_bp);
    check("model_pending", pending, m_pending);
    check("model_merged", {3'b000, merged}, {3'b000, m_merged});
    if (buttons_pressed != '0) issue_cnt++;
    if (merged) merged_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input string name, input logic [3:0] exp);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (buttons_pressed != '0) break;
    end
    check(name, buttons_pressed, exp);
  endtask

  task automatic settle();
    key_n = '1; int_active = 1'b0;
    tick(30);
  endtask

  int i0, mg0;

  initial begin
    rst_n = 1'b0; key_n = '1; int_active = 1'b0;
    tick(3);
    check("reset_bp", buttons_pressed, 4'b0000);
    check("reset_pending", pending, 4'b0000);
    check("reset_merged", {3'b000, merged}, 4'b0000);
    rst_n = 1'b1;
    tick(5);

    // single press
    key_n[1] = 1'b0;
    tick(7);
    check("single_before", buttons_pressed, 4'b0000);
    tick(1);
    check("single_issue", buttons_pressed, 4'b0010);
    check("single_pend_clr", pending, 4'b0000);
    tick(1);
    check("single_one_cycle", buttons_pressed, 4'b0000);
    tick(1);
    int_active = 1'b1;
    tick(10);
    int_active = 1'b0; key_n[1] = 1'b1;
    tick(15);
    check("single_pend_end", pending, 4'b0000);
    settle();

    // bounce
    i0 = issue_cnt;
    for (int k = 0; k < 6; k++) begin
      key_n[0] = ~key_n[0];
      tick(2);
    end
    key_n[0] = 1'b1;
    tick(12);
    check("bounce_pending", pending, 4'b0000);
    check("bounce_issues", 4'(issue_cnt - i0), 4'd0);
    settle();

    // priority
    key_n[3] = 1'b0; key_n[0] = 1'b0;
    tick(7);
    check("prio_pending", pending, 4'b1001);
    tick(1);
    check("prio_first", buttons_pressed, 4'b1000);
    check("prio_pend_left", pending, 4'b0001);
    tick(1);
    int_active = 1'b1;
    i0 = issue_cnt;
    tick(6);
    check("prio_held", 4'(issue_cnt - i0), 4'd0);
    int_active = 1'b0; key_n = '1;
    wait_issue("prio_second", 4'b0001);
    settle();

    // blocked by active handler
    int_active = 1'b1; key_n[2] = 1'b0;
    tick(10);
    check("blocked_pending", pending, 4'b0100);
    check("blocked_bp", buttons_pressed, 4'b0000);
    int_active = 1'b0;
    tick(1);
    check("blocked_issue", buttons_pressed, 4'b0100);
    key_n[2] = 1'b1;
    settle();

    // timeout: second request waits out the full ack window
    key_n[1] = 1'b0;
    wait_issue("timeout_issue", 4'b0010);
    key_n[1] = 1'b1; key_n[0] = 1'b0;
    tick(9);
    check("timeout_wait_bp", buttons_pressed, 4'b0000);
    check("timeout_wait_pend", pending, 4'b0001);
    tick(1);
    check("timeout_next", buttons_pressed, 4'b0001);
    key_n[0] = 1'b1;
    settle();

    // merge
    int_active = 1'b1; mg0 = merged_cnt;
    key_n[1] = 1'b0; tick(9);
    key_n[1] = 1'b1; tick(9);
    key_n[1] = 1'b0; tick(9);
    check("merge_pulse", 4'(merged_cnt - mg0), 4'd1);
    check("merge_pending", pending, 4'b0010);
    i0 = issue_cnt;
    key_n[1] = 1'b1; int_active = 1'b0;
    tick(25);
    check("merge_one_issue", 4'(issue_cnt - i0), 4'd1);
    settle();

    // reset mid-operation
    key_n[3:1] = 3'b000;
    tick(7);
    check("rst_pend_pre", pending, 4'b1110);
    tick(1);
    check("rst_issue", buttons_pressed, 4'b1000);
    tick(3);
    check("rst_pend_wait", pending, 4'b0110);
    rst_n = 1'b0;
    #1;
    check("rst_bp_now", buttons_pressed, 4'b0000);
    check("rst_pend_now", pending, 4'b0000);
    check("rst_merged_now", {3'b000, merged}, 4'b0000);
    key_n = '1;
    tick(3);
    rst_n = 1'b1;
    i0 = issue_cnt;
    tick(20);
    check("rst_no_issue", 4'(issue_cnt - i0), 4'd0);

    // random activity
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      for (int b = 0; b < NUM_BTN; b++)
        if ($urandom_range(0, 15) == 0) key_n[b] = ~key_n[b];
      if ($urandom_range(0, 9) == 0) int_active = ~int_active;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
    end
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
